// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex scan driver for one shared 7-segment decoder. New values load through a ready/load handshake and apply only at frame boundaries.
// Optional leading-zero blanking: define HEX_SCAN_LZB_EN.
module hex_scan_driver #(
    parameter int TICK_DIV   = 50000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic                    ready,
    output logic                    a,
    output logic                    b,
    output logic                    c,
    output logic                    d,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {IDLE, PENDING} state_t;

    logic [PW-1:0]           prescaler_reg;
    logic [IW-1:0]           idx_reg;
    logic [4*NUM_DIGITS-1:0] display_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [3:0]              nib_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    state_t                  state_reg, state_next;

    logic                    tick;
    logic                    frame_end;
    logic                    shadow_load;
    logic                    display_load;
    logic [3:0]              nib_next;
    logic [NUM_DIGITS-1:0]   an_next;

    assign tick      = (prescaler_reg == PW'(TICK_DIV - 1));
    assign frame_end = tick && (idx_reg == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prescaler_reg <= '0;
            idx_reg       <= '0;
        end else if (tick) begin
            prescaler_reg <= '0;
            if (idx_reg == IW'(NUM_DIGITS - 1))
                idx_reg <= '0;
            else
                idx_reg <= idx_reg + 1'b1;
        end else begin
            prescaler_reg <= prescaler_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // A load accepted on a frame_end cycle lands in PENDING and waits a full frame.
    always_comb begin
        state_next   = state_reg;
        shadow_load  = 1'b0;
        display_load = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    shadow_load = 1'b1;
                    state_next  = PENDING;
                end
            end
            PENDING: begin
                if (frame_end) begin
                    display_load = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow_reg  <= '0;
            display_reg <= '0;
        end else begin
            if (shadow_load)
                shadow_reg <= value;
            if (display_load)
                display_reg <= shadow_reg;
        end
    end

`ifdef HEX_SCAN_LZB_EN
    // upper_zero[gi]: nibbles gi..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] upper_zero;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
        assign upper_zero[gi] = ~|display_reg[4*NUM_DIGITS-1:4*gi];
    end
`endif

    always_comb begin
        nib_next = display_reg[4*idx_reg +: 4];
        an_next  = ~(NUM_DIGITS'(1) << idx_reg);
`ifdef HEX_SCAN_LZB_EN
        if ((idx_reg != '0) && upper_zero[idx_reg])
            an_next = '1;
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            nib_reg <= 4'h0;
            an_reg  <= '1;
        end else begin
            nib_reg <= nib_next;
            an_reg  <= an_next;
        end
    end

    assign {a, b, c, d} = nib_reg;
    assign an           = an_reg;
    assign ready        = (state_reg == IDLE);

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver: a frame-level model compared every cycle, plus directed literal checks.
module tb_hex_scan_driver;

    localparam int T = 4;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        ready, a, b, c, d;
    logic [3:0]  an;
    logic [3:0]  nib;

    int checks = 0;
    int errors = 0;

    hex_scan_driver #(.TICK_DIV(T), .NUM_DIGITS(N)) dut (
        .clock(clock), .resetn(resetn), .load(load), .value(value),
        .ready(ready), .a(a), .b(b), .c(c), .d(d), .an(an)
    );

    always #5 clock = ~clock;
    assign nib = {a, b, c, d};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges since reset release, plus displayed/shadow values and pending flag.
    int          m_cnt = 0;
    int          m_idx;
    logic        m_fe;
    logic        m_pend = 1'b0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    logic [3:0]  e_an = 4'hF;
    logic [3:0]  e_nib = 4'h0;

    always @(posedge clock) begin
        if (!resetn) begin
            m_cnt = 0; m_pend = 1'b0; m_disp = 16'h0; m_shadow = 16'h0;
            e_an = 4'hF; e_nib = 4'h0;
        end else begin
            m_idx = (m_cnt / T) % N;
            m_fe  = ((m_cnt % (T * N)) == T * N - 1);
            e_nib = 4'((m_disp >> (4 * m_idx)) & 16'hF);
            e_an  = ~(4'b0001 << m_idx);
`ifdef HEX_SCAN_LZB_EN
            if (m_idx > 0 && (m_disp >> (4 * m_idx)) == 16'h0)
                e_an = 4'hF;
`endif
            if (m_pend) begin
                if (m_fe) begin
                    m_disp = m_shadow;
                    m_pend = 1'b0;
                end
            end else if (load) begin
                m_shadow = value;
                m_pend   = 1'b1;
            end
            m_cnt++;
        end
        #1;
        chk("model_an", 32'(an), 32'(e_an));
        chk("model_nib", 32'(nib), 32'(e_nib));
        chk("model_ready", 32'(ready), 32'(!m_pend));
    end

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ready) begin ok = 1; break; end
        end
        if (!ok) chk("wait_ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic load_value(input logic [15:0] v);
        wait_ready();
        load = 1'b1; value = v;
        @(negedge clock);
        load = 1'b0;
        chk("ready_drop", 32'(ready), 32'd0);
    endtask

    // Wait for the next edge whose outputs show digit enable an_t, then check the nibble.
    task automatic expect_digit(input string name, input logic [3:0] an_t, input logic [3:0] nib_t);
        bit ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clock); #1;
            if (an == an_t) begin ok = 1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'(an), 32'(an_t));
        else     chk(name, 32'(nib), 32'(nib_t));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_ready", 32'(ready), 32'd1);
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("first_edge_an", 32'(an), 32'hE);
        chk("first_edge_nib", 32'(nib), 32'h0);
        repeat (20) @(negedge clock);

        // Load and apply
        load_value(16'h3A7F);
        wait_ready();
        expect_digit("3a7f_d0", 4'b1110, 4'hF);
        expect_digit("3a7f_d1", 4'b1101, 4'h7);
        expect_digit("3a7f_d2", 4'b1011, 4'hA);
        expect_digit("3a7f_d3", 4'b0111, 4'h3);

        // Second load while pending is ignored
        load_value(16'h1111);
        load = 1'b1; value = 16'h2222;
        @(negedge clock);
        load = 1'b0;
        wait_ready();
        expect_digit("1111_d0", 4'b1110, 4'h1);
        expect_digit("1111_d1", 4'b1101, 4'h1);
        expect_digit("1111_d2", 4'b1011, 4'h1);
        expect_digit("1111_d3", 4'b0111, 4'h1);

        // Load exactly on the frame_end cycle
        wait_ready();
        for (int i = 0; i < 40 && (m_cnt % (T * N)) != T * N - 1; i++) @(negedge clock);
        chk("fe_align", 32'(m_cnt % (T * N)), 32'(T * N - 1));
        load = 1'b1; value = 16'hBEEF;
        @(negedge clock);
        load = 1'b0;
        expect_digit("beef_old_d0", 4'b1110, 4'h1);
        expect_digit("beef_old_d3", 4'b0111, 4'h1);
        chk("beef_still_pending", 32'(ready), 32'd0);
        wait_ready();
        expect_digit("beef_d0", 4'b1110, 4'hF);
        expect_digit("beef_d1", 4'b1101, 4'hE);
        expect_digit("beef_d2", 4'b1011, 4'hE);
        expect_digit("beef_d3", 4'b0111, 4'hB);

        // Reset while pending
        load_value(16'h5555);
        resetn = 1'b0;
        #1;
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_ready", 32'(ready), 32'd1);
        chk("midreset_nib", 32'(nib), 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        expect_digit("postreset_d0", 4'b1110, 4'h0);
        expect_digit("postreset_d3", 4'b0111, 4'h0);
        repeat (T * N) @(negedge clock);

`ifdef HEX_SCAN_LZB_EN
        load_value(16'h0040);
        wait_ready();
        expect_digit("lzb_d1", 4'b1101, 4'h4);
        expect_digit("lzb_d0", 4'b1110, 4'h0);
        repeat (2 * T * N) @(negedge clock);
        load_value(16'h0000);
        wait_ready();
        expect_digit("lzb_zero_d0", 4'b1110, 4'h0);
        repeat (2 * T * N) @(negedge clock);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Time-multiplexes an N-digit hex value onto a single shared 7-segment decoder.
- Sits directly upstream of the hex-to-segment decoder. It drives that decoder's four nibble inputs (A = MSB … D = LSB) plus active-low per-digit enables.
- Accepts new display values via a ready/load handshake. Values apply only at frame boundaries, so a value never tears mid-scan.

Parameters:
- TICK_DIV, 50000: Clock cycles each digit stays lit; legal range ≥ 2.
- NUM_DIGITS, 4: Number of digits scanned; legal range 1–8. Value width is 4*NUM_DIGITS.

Ports:
- Clock, in, 1: System clock; all state changes on the rising edge.
- Resetn, in, 1: Asynchronous, active-low reset.
- Load, in, 1: Value-load strobe, sampled on the rising edge of Clock.
- Value, in, 4*NUM_DIGITS: New display value; digit 0 = Value[3:0].
- Ready, out, 1: High when Load will be accepted.
- A, out, 1: Nibble bit 3 to the decoder.
- B, out, 1: Nibble bit 2.
- C, out, 1: Nibble bit 1.
- D, out, 1: Nibble bit 0.
- AN, out, NUM_DIGITS: Active-low digit enables; at most one bit low at a time.

Behaviour:
- Clock/reset (decided):
  - One clock, Clock.
  - Resetn is asynchronous and active-low. Assertion immediately forces all state to reset values, including mid-frame or mid-handshake.
- Reset values:
  - prescaler = 0, digit index = 0, display reg = 0, shadow reg = 0.
  - State = IDLE, Ready = 1.
  - AN = all ones (all digits dark); A, B, C, D = 0.
- Prescaler:
  - Counts 0 … TICK_DIV-1, then wraps to 0.
  - tick = (prescaler == TICK_DIV-1).
- Digit index:
  - Increments on tick; wraps from NUM_DIGITS-1 to 0.
  - frame_end = tick && (index == NUM_DIGITS-1).
- Outputs (registered, one cycle latency from index/display reg):
  - {A,B,C,D} = display_reg[4*idx+3 : 4*idx].
  - AN = ~(1 << idx).
  - The first rising edge after reset release drives AN = …1110 and the nibble for digit 0.
  - Nibble and AN update on the same edge.
- Handshake FSM, state IDLE:
  - Ready = 1.
  - Load = 1: Value captures into shadow; state goes to PENDING.
- Handshake FSM, state PENDING:
  - Ready = 0; Load is ignored (Value not sampled).
  - On frame_end: shadow copies into display reg and state returns to IDLE.
  - Ready is 1 again the cycle after the copy.
- Simultaneous events:
  - Load accepted on the same cycle as frame_end (in IDLE): the value is NOT applied at that boundary. It waits for the next frame_end, one full frame later.
  - A new display reg first appears on the outputs at the digit-0 slot following the copy.
- Display tearing: display reg changes only at frame_end, so one frame never mixes old and new nibbles.
- NUM_DIGITS = 1: index is constant 0, AN = 0 after the first edge, and frame_end = tick.

Optional Feature:
- Macro: HEX_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - A digit i > 0 is blanked (its AN bit held high during its slot) when display_reg nibbles i … NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - {A,B,C,D} still carries the nibble, and slot timing is unchanged.
- Not defined: every digit is enabled in its slot regardless of value.

Test Plan:
- Reset/scan, TICK_DIV=4, NUM_DIGITS=4:
  - Stimulus: hold Resetn=0 for 3 cycles, release.
  - Response: AN=1111 during reset. After release, AN steps 1110 → 1101 → 1011 → 0111 → 1110, each held exactly 4 cycles. ABCD = 0000 throughout.
- Load and apply:
  - Stimulus: in IDLE, Load=1 with Value=16'h3A7F.
  - Response: Ready drops to 0 the next cycle and rises after the next frame_end. Next frame shows ABCD = F (AN 1110), 7 (1101), A (1011), 3 (0111).
- Load ignored while pending:
  - Stimulus: Load 16'h1111; then, while Ready=0, Load 16'h2222.
  - Response: display shows 1111; the 2222 value never appears.
- Load on frame_end:
  - Stimulus: assert Load with 16'hBEEF exactly on the frame_end cycle.
  - Response: the frame after shows the old value; BEEF appears one frame later.
- Reset mid-pending:
  - Stimulus: Load 16'h5555, then assert Resetn=0 before frame_end.
  - Response: immediately AN=1111 and Ready=1; after release, displayed value is 0000.
- HEX_SCAN_LZB_EN defined:
  - Stimulus: Value=16'h0040.
  - Response: digits 3 and 2 have AN bit high during their slots; digit 1 shows 4, digit 0 shows 0.
  - With Value=16'h0000, only digit 0 is lit.
